// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: forwards one cache's request at a time to a single RAM port.
// Optional grant watchdog built when ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [1:0]        reqREN,
    input  logic [1:0]        reqWEN,
    input  logic [WORD_W-1:0] reqaddr0,
    input  logic [WORD_W-1:0] reqaddr1,
    input  logic [WORD_W-1:0] reqstore0,
    input  logic [WORD_W-1:0] reqstore1,
    output logic [1:0]        reqwait,
    output logic [WORD_W-1:0] reqload,
    output logic              memREN,
    output logic              memWEN,
    output logic [WORD_W-1:0] memaddr,
    output logic [WORD_W-1:0] memstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              timeout
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SERVE0 = 2'd1;
    localparam logic [1:0] SERVE1 = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]        state_reg, state_next;
    logic              last_reg, last_next;
    logic [1:0]        active;
    logic [WORD_W-1:0] addr_sel [2];
    logic [WORD_W-1:0] store_sel [2];
    logic              serving;
    logic              sel;
    logic              granted_active;
    logic              access;
    logic              expire;

    assign addr_sel[0]  = reqaddr0;
    assign addr_sel[1]  = reqaddr1;
    assign store_sel[0] = reqstore0;
    assign store_sel[1] = reqstore1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_active
            assign active[gi] = reqREN[gi] | reqWEN[gi];
        end
    endgenerate

    assign serving        = (state_reg == SERVE0) || (state_reg == SERVE1);
    assign sel            = (state_reg == SERVE1);
    assign granted_active = serving & active[sel];
    assign access         = granted_active & (ramstate == RAM_ACCESS);

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        memREN     = 1'b0;
        memWEN     = 1'b0;
        memaddr    = '0;
        memstore   = '0;
        reqwait    = active;
        reqload    = '0;
        case (state_reg)
            IDLE: begin
                // On a tie the requester that did not complete last goes first.
                if (active == 2'b11)
                    state_next = last_reg ? SERVE0 : SERVE1;
                else if (active[0])
                    state_next = SERVE0;
                else if (active[1])
                    state_next = SERVE1;
            end
            SERVE0, SERVE1: begin
                if (!active[sel]) begin
                    state_next = IDLE;
                end else begin
                    memWEN   = reqWEN[sel];
                    memREN   = reqREN[sel] & ~reqWEN[sel];
                    memaddr  = addr_sel[sel];
                    memstore = store_sel[sel];
                    if (access) begin
                        reqwait[sel] = 1'b0;
                        reqload      = ramload;
                        last_next    = sel;
                        // Hand straight over to a waiting peer without an idle bubble.
                        if (active[~sel])
                            state_next = sel ? SERVE0 : SERVE1;
                        else
                            state_next = IDLE;
                    end else if (expire) begin
                        last_next  = sel;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_reg, cnt_next;
    logic [7:0] cnt_inc;

    assign cnt_inc = cnt_reg + 8'd1;
    // Fires on the TIMEOUT-th consecutive SERVE cycle without ACCESS.
    assign expire  = granted_active & ~access & (cnt_inc == TIMEOUT_CNT);
    assign timeout = expire;

    always_comb begin
        cnt_next = 8'd0;
        if (serving && (state_next == state_reg))
            cnt_next = cnt_inc;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            cnt_reg <= 8'd0;
        else
            cnt_reg <= cnt_next;
    end
`else
    // Without the watchdog a grant is held until ACCESS or the requester drops.
    assign expire  = (TIMEOUT_CNT == 8'd0) & 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inline checks plus a scoreboard of expected RAM transactions
// consumed by a monitor whenever an ACCESS completes.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  reqREN, reqWEN;
    logic [31:0] reqaddr0, reqaddr1, reqstore0, reqstore1;
    logic [1:0]  reqwait;
    logic [31:0] reqload;
    logic        memREN, memWEN;
    logic [31:0] memaddr, memstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        idx;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [1:0] mon_act;
    logic       mon_bad;

    mem_arbiter #(.WORD_W(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .reqREN(reqREN), .reqWEN(reqWEN),
        .reqaddr0(reqaddr0), .reqaddr1(reqaddr1),
        .reqstore0(reqstore0), .reqstore1(reqstore1),
        .reqwait(reqwait), .reqload(reqload),
        .memREN(memREN), .memWEN(memWEN),
        .memaddr(memaddr), .memstore(memstore),
        .ramload(ramload), .ramstate(ramstate),
        .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic neg();
        @(negedge CLK);
    endtask

    task automatic push(input logic idx, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] store, input logic [31:0] load);
        exp_t e;
        e.idx = idx; e.ren = ren; e.wen = wen;
        e.addr = addr; e.store = store; e.load = load;
        sb.push_back(e);
    endtask

    // Monitor: every completed RAM access must match the next scoreboard entry.
    always @(negedge CLK) begin
        if (nRST === 1'b1 && ramstate == 2'd2 && (memREN | memWEN)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL txn_unexpected addr %h ren %b wen %b", memaddr, memREN, memWEN);
            end else begin
                mon_e   = sb.pop_front();
                mon_act = reqREN | reqWEN;
                mon_bad = (reqwait[mon_e.idx] !== 1'b0) || (reqwait[~mon_e.idx] !== mon_act[~mon_e.idx]) ||
                          (memREN !== mon_e.ren) || (memWEN !== mon_e.wen) ||
                          (memaddr !== mon_e.addr) || (memstore !== mon_e.store) ||
                          (reqload !== mon_e.load);
                $display("txn core%0d ren %b wen %b addr %h store %h load %h wait %b",
                         mon_e.idx, memREN, memWEN, memaddr, memstore, reqload, reqwait);
                if (mon_bad) begin
                    errors++;
                    $display("FAIL txn core%0d got ren %b wen %b addr %h store %h load %h wait %b want ren %b wen %b addr %h store %h load %h",
                             mon_e.idx, memREN, memWEN, memaddr, memstore, reqload, reqwait,
                             mon_e.ren, mon_e.wen, mon_e.addr, mon_e.store, mon_e.load);
                end
            end
        end
    end

    initial begin
        nRST = 1'b0; reqREN = 2'b00; reqWEN = 2'b00;
        reqaddr0 = 32'h100; reqaddr1 = 32'h0; reqstore0 = 32'h0; reqstore1 = 32'h0;
        ramload = 32'hFFFF_FFFF; ramstate = 2'd2;

        // Reset state: nothing forwarded, waits mirror the active bits.
        #2 reqREN = 2'b01;
        neg();
        chk("rst_memREN", memREN, 0);
        chk("rst_memWEN", memWEN, 0);
        chk("rst_memaddr", memaddr, 0);
        chk("rst_memstore", memstore, 0);
        chk("rst_reqload", reqload, 0);
        chk("rst_reqwait", reqwait, 2'b01);
        chk("rst_timeout", timeout, 0);
        step();
        nRST = 1'b1; reqREN = 2'b00; ramstate = 2'd0; ramload = 32'h0;

        // Single read, BUSY twice then ACCESS.
        reqREN = 2'b01; reqaddr0 = 32'h100;
        neg(); chk("rd_idle_memREN", memREN, 0); chk("rd_idle_wait", reqwait, 2'b01);
        step(); ramstate = 2'd1;
        neg(); chk("rd_busy_memREN", memREN, 1); chk("rd_busy_addr", memaddr, 32'h100);
        chk("rd_busy_wait", reqwait, 2'b01);
        step();
        neg(); chk("rd_busy_load", reqload, 0);
        step(); ramstate = 2'd2; ramload = 32'hDEADBEEF;
        push(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
        step(); ramload = 32'h0;
        neg(); chk("rd_back_idle_memREN", memREN, 0); chk("rd_back_idle_wait", reqwait, 2'b01);
        step(); reqREN = 2'b00; ramstate = 2'd0;
        neg(); chk("drop_in_serve_memREN", memREN, 0); chk("drop_in_serve_wait", reqwait, 2'b00);
        step();

        // Tie from reset: core0 first, core1 back-to-back, next tie to core0.
        nRST = 1'b0; step(); nRST = 1'b1;
        reqREN = 2'b11; reqaddr0 = 32'h200; reqaddr1 = 32'h300;
        neg(); chk("tie_idle_wait", reqwait, 2'b11); chk("tie_idle_memREN", memREN, 0);
        step(); ramstate = 2'd2; ramload = 32'hA0A0A0A0;
        push(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'hA0A0A0A0);
        neg(); chk("tie_serve0_wait", reqwait, 2'b10);
        step(); reqREN = 2'b10; ramload = 32'hB1B1B1B1;
        push(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 32'hB1B1B1B1);
        step(); reqREN = 2'b11; ramstate = 2'd0;
        neg(); chk("tie2_idle_memREN", memREN, 0);
        step(); ramstate = 2'd2; ramload = 32'hC0C0C0C0;
        push(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'hC0C0C0C0);
        neg(); chk("tie2_serve0_wait", reqwait, 2'b10);
        step(); reqREN = 2'b10; ramload = 32'hD1D1D1D1;
        push(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 32'hD1D1D1D1);
        step(); reqREN = 2'b00; ramstate = 2'd0; ramload = 32'h0;
        step();

        // Core1 with REN and WEN both set is a write.
        reqREN = 2'b10; reqWEN = 2'b10; reqaddr1 = 32'h204; reqstore1 = 32'h12345678;
        neg(); chk("wr_idle_memWEN", memWEN, 0);
        step(); ramstate = 2'd1;
        neg(); chk("wr_memWEN", memWEN, 1); chk("wr_memREN", memREN, 0);
        chk("wr_memstore", memstore, 32'h12345678); chk("wr_memaddr", memaddr, 32'h204);
        step(); ramstate = 2'd2;
        push(1'b1, 1'b0, 1'b1, 32'h204, 32'h12345678, 32'h0);
        step(); reqREN = 2'b00; reqWEN = 2'b00; ramstate = 2'd0; reqstore1 = 32'h0;
        step();

        // Core0 abandons after one BUSY cycle; priority pointer must not move.
        reqREN = 2'b01; reqaddr0 = 32'h400;
        step(); ramstate = 2'd1;
        neg(); chk("abandon_busy_memREN", memREN, 1);
        step(); reqREN = 2'b00;
        neg(); chk("abandon_memREN", memREN, 0); chk("abandon_wait", reqwait, 2'b00);
        step(); reqREN = 2'b11; reqaddr1 = 32'h300; ramstate = 2'd0;
        neg(); chk("abandon_idle_memREN", memREN, 0);
        step(); ramstate = 2'd2; ramload = 32'h40;
        push(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 32'h40);
        step(); reqREN = 2'b10; ramload = 32'h41;
        push(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 32'h41);
        step(); reqREN = 2'b00; ramstate = 2'd0; ramload = 32'h0;
        step();

        // Reset pulse mid-SERVE1 drops enables at once; afterwards core0 wins the tie.
        reqREN = 2'b10; reqaddr1 = 32'h500;
        step(); ramstate = 2'd1;
        neg(); chk("rst_mid_busy_memREN", memREN, 1);
        #2 nRST = 1'b0; ramstate = 2'd2; ramload = 32'h99;
        #1;
        chk("rst_mid_memREN", memREN, 0); chk("rst_mid_memWEN", memWEN, 0);
        chk("rst_mid_wait", reqwait, 2'b10); chk("rst_mid_load", reqload, 0);
        step(); nRST = 1'b1; ramstate = 2'd0; ramload = 32'h0;
        reqREN = 2'b11; reqaddr0 = 32'h600;
        neg(); chk("rst_mid_idle_memREN", memREN, 0);
        step(); ramstate = 2'd2; ramload = 32'h60;
        push(1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 32'h60);
        step(); reqREN = 2'b10; ramload = 32'h50;
        push(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 32'h50);
        step(); reqREN = 2'b00; ramstate = 2'd0; ramload = 32'h0;
        step();

`ifdef ARB_TIMEOUT_EN
        // RAM stuck BUSY: abort on the 4th SERVE cycle, then core1 gets the grant.
        reqREN = 2'b11; reqaddr0 = 32'h700; reqaddr1 = 32'h710; ramstate = 2'd1;
        neg(); chk("to_idle_timeout", timeout, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            neg();
            chk("to_serve_timeout", timeout, (k == 3) ? 32'd1 : 32'd0);
            chk("to_serve_memaddr", memaddr, 32'h700);
            if (k == 3) chk("to_fire_wait", reqwait, 2'b11);
            step();
        end
        neg(); chk("to_after_memREN", memREN, 0); chk("to_after_timeout", timeout, 0);
        step(); ramstate = 2'd2; ramload = 32'h71;
        push(1'b1, 1'b1, 1'b0, 32'h710, 32'h0, 32'h71);
        step(); reqREN = 2'b01; ramload = 32'h70;
        push(1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 32'h70);
        step(); reqREN = 2'b00; ramstate = 2'd0; ramload = 32'h0;
        step();
`else
        // Without the watchdog a stuck grant is simply held.
        reqREN = 2'b01; reqaddr0 = 32'h700; ramstate = 2'd1;
        step();
        for (int k = 0; k < 6; k++) begin
            neg();
            chk("hold_memREN", memREN, 1);
            chk("hold_timeout", timeout, 0);
            step();
        end
        ramstate = 2'd2; ramload = 32'h70;
        push(1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 32'h70);
        step(); reqREN = 2'b00; ramstate = 2'd0; ramload = 32'h0;
        step();
`endif

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
